// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the shift-and-add multiplier controller and datapath.
// Holds the register op codes, the ULA op codes, the sequencer state enum,
// the packed control bundle and the Moore decode from state to controls.
package mult_ctrl_pkg;

  // Register op codes (X shifts left, Y shifts right)
  localparam logic [1:0] HOLD  = 2'b00;
  localparam logic [1:0] LOAD  = 2'b01;
  localparam logic [1:0] CLEAR = 2'b10;
  localparam logic [1:0] SHIFT = 2'b11;

  // ULA op codes
  localparam logic ADD  = 1'b0;
  localparam logic PASS = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_X = 3'd1,
    LOAD_Y = 3'd2,
    EXEC   = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Control bundle driven towards the datapath
  typedef struct packed {
    logic [1:0] x_op;
    logic [1:0] y_op;
    logic [1:0] z_op;
    logic       ula_op;
    logic       val_sel;
    logic       busy;
    logic       done;
  } ctrl_t;

  // Moore part of the control decode; z_op in EXEC is refined by the caller
  function automatic ctrl_t decode_ctrl(input state_e s);
    ctrl_t c;
    c.x_op    = HOLD;
    c.y_op    = HOLD;
    c.z_op    = HOLD;
    c.ula_op  = ADD;
    c.val_sel = 1'b0;
    c.busy    = 1'b0;
    c.done    = 1'b0;
    case (s)
      LOAD_X: begin
        c.x_op    = LOAD;
        c.y_op    = CLEAR;
        c.z_op    = CLEAR;
        c.val_sel = 1'b0;
        c.busy    = 1'b1;
      end
      LOAD_Y: begin
        c.y_op    = LOAD;
        c.val_sel = 1'b1;
        c.busy    = 1'b1;
      end
      EXEC: begin
        c.x_op   = SHIFT;
        c.y_op   = SHIFT;
        c.ula_op = ADD;
        c.busy   = 1'b1;
      end
      DONE: begin
        c.done = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter for the EXEC phase of the multiplier sequencer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear to 0 (priority over en_i)
//   en_i       : count one iteration; saturates at WIDTH-1 so it never wraps
//   last_o     : registered flag, high while the count equals WIDTH-1
module mult_iter_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             last_q, last_d;

  // Next count; holding at the last value keeps power-of-two widths from wrapping
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (clr_i) begin
      bit_cnt_d = '0;
    end else if (en_i && !last_q) begin
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end
    last_d = (bit_cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
      last_q    <= (WIDTH == 1);
    end else begin
      bit_cnt_q <= bit_cnt_d;
      last_q    <= last_d;
    end
  end

  assign last_o = last_q;

endmodule

// File: rtl/mult_sequencer.sv
// Start/done handshaked sequencer for the shift-and-add multiplier datapath.
// Loads operand A into X and operand B into Y, then runs one EXEC cycle per
// multiplier bit (optionally leaving early once Y is zero) and pulses done.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : multiply request, sampled only in IDLE
//   abort          : synchronous cancel in any non-IDLE state
//   y_lsb, y_zero  : datapath Y[0] and Y==0 status
//   x_op,y_op,z_op : register op codes (HOLD/LOAD/CLEAR/SHIFT)
//   ula_op         : 0=ADD (Z+X), 1=PASS
//   val_sel        : load mux, 0=A into X, 1=B into Y
//   busy           : high from LOAD_X through EXEC
//   done           : one-cycle pulse, Z holds the product
module mult_sequencer
  import mult_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       y_lsb,
  input  logic       y_zero,
  output logic [1:0] x_op,
  output logic [1:0] y_op,
  output logic [1:0] z_op,
  output logic       ula_op,
  output logic       val_sel,
  output logic       busy,
  output logic       done
);

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   cnt_clr, cnt_en, cnt_last;
  logic   exec_exit;

  assign cnt_clr = (state_q == LOAD_X);
  assign cnt_en  = (state_q == EXEC);

  // Iteration counter
  mult_iter_counter #(
    .WIDTH (WIDTH)
  ) u_iter_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .last_o (cnt_last)
  );

  assign exec_exit = cnt_last || (EARLY_EXIT && y_zero);

  // Next-state logic; abort outranks every exit condition outside IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD_X;
      end
      LOAD_X: begin
        state_d = abort ? IDLE : LOAD_Y;
      end
      LOAD_Y: begin
        state_d = abort ? IDLE : EXEC;
      end
      EXEC: begin
        if (abort) begin
          state_d = IDLE;
        end else if (exec_exit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ctrl_d = decode_ctrl(state_d);
  end

  // State and registered Moore controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign x_op    = ctrl_q.x_op;
  assign y_op    = ctrl_q.y_op;
  assign ula_op  = ctrl_q.ula_op;
  assign val_sel = ctrl_q.val_sel;
  assign busy    = ctrl_q.busy;
  assign done    = ctrl_q.done;

  // z_op is the one Mealy output: in EXEC it accumulates only on a set multiplier bit
  assign z_op = (state_q == EXEC) ? ((y_lsb && !y_zero) ? LOAD : HOLD)
                                  : ctrl_q.z_op;

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: two instances (EARLY_EXIT=0 and 1) each driving a
// behavioural X/Y/Z/ULA model, checked against hand-computed vectors.
module tb_mult_sequencer;
  import mult_ctrl_pkg::*;

  localparam int unsigned W    = 4;
  localparam int          NLOG = 32;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] a_in;
  logic [7:0] b_in;

  logic       y_lsb   [2];
  logic       y_zero  [2];
  logic [1:0] x_op    [2];
  logic [1:0] y_op    [2];
  logic [1:0] z_op    [2];
  logic       ula_op  [2];
  logic       val_sel [2];
  logic       busy    [2];
  logic       done    [2];
  logic [7:0] z_mon   [2];

  int n_chk  = 0;
  int n_fail = 0;

  logic [1:0] zop_log  [2][NLOG];
  logic       busy_log [2][NLOG];
  logic       done_log [2][NLOG];
  logic [7:0] z_log    [2][NLOG];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gen_inst
    logic [7:0] mx;
    logic [3:0] my;
    logic [7:0] mz;
    logic [7:0] lv;

    mult_sequencer #(
      .WIDTH      (W),
      .EARLY_EXIT (g == 1)
    ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .abort   (abort),
      .y_lsb   (y_lsb[g]),
      .y_zero  (y_zero[g]),
      .x_op    (x_op[g]),
      .y_op    (y_op[g]),
      .z_op    (z_op[g]),
      .ula_op  (ula_op[g]),
      .val_sel (val_sel[g]),
      .busy    (busy[g]),
      .done    (done[g])
    );

    assign lv = val_sel[g] ? b_in : a_in;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mx <= '0;
        my <= '0;
        mz <= '0;
      end else begin
        case (x_op[g])
          LOAD:    mx <= lv;
          CLEAR:   mx <= '0;
          SHIFT:   mx <= mx << 1;
          default: ;
        endcase
        case (y_op[g])
          LOAD:    my <= lv[3:0];
          CLEAR:   my <= '0;
          SHIFT:   my <= my >> 1;
          default: ;
        endcase
        case (z_op[g])
          LOAD:    mz <= (ula_op[g] == PASS) ? mx : mz + mx;
          CLEAR:   mz <= '0;
          SHIFT:   mz <= mz << 1;
          default: ;
        endcase
      end
    end

    assign y_lsb[g]  = my[0];
    assign y_zero[g] = (my == 4'd0);
    assign z_mon[g]  = mz;
  end

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Entered and left #1 after a rising edge; cycle c drives smask[c]/amask[c],
  // log index c+1 is the cycle that follows the edge
  task automatic run(input logic [7:0] a, input logic [7:0] b,
                     input logic [31:0] smask, input logic [31:0] amask,
                     input int ncyc);
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < NLOG; k++) begin
        zop_log[i][k]  = HOLD;
        busy_log[i][k] = 1'b0;
        done_log[i][k] = 1'b0;
        z_log[i][k]    = '0;
      end
    end
    a_in = a;
    b_in = b;
    for (int c = 0; c < ncyc; c++) begin
      start = smask[c];
      abort = amask[c];
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        zop_log[i][c+1]  = z_op[i];
        busy_log[i][c+1] = busy[i];
        done_log[i][c+1] = done[i];
        z_log[i][c+1]    = z_mon[i];
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  function automatic int first_done(input int i);
    for (int k = 1; k < NLOG; k++) begin
      if (done_log[i][k]) return k;
    end
    return -1;
  endfunction

  function automatic int done_count(input int i);
    int n = 0;
    for (int k = 1; k < NLOG; k++) begin
      if (done_log[i][k]) n++;
    end
    return n;
  endfunction

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] z;
    int         lat0;
    int         lat1;
  } vec_t;

  vec_t vecs [7];

  task automatic check_result(input string tag, input int i,
                              input int exp_lat, input int exp_z);
    int fd;
    fd = first_done(i);
    check($sformatf("%s[%0d] done_latency", tag, i), fd, exp_lat);
    check($sformatf("%s[%0d] done_pulses", tag, i), done_count(i), 1);
    if (fd > 0) begin
      check($sformatf("%s[%0d] product", tag, i), int'(z_log[i][fd]), exp_z);
      check($sformatf("%s[%0d] busy_at_done", tag, i), int'(busy_log[i][fd]), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{a: 8'd3,  b: 8'd5,  z: 8'd15,  lat0: 7, lat1: 7};
    vecs[1] = '{a: 8'd3,  b: 8'd1,  z: 8'd3,   lat0: 7, lat1: 5};
    vecs[2] = '{a: 8'd7,  b: 8'd0,  z: 8'd0,   lat0: 7, lat1: 4};
    vecs[3] = '{a: 8'd15, b: 8'd15, z: 8'd225, lat0: 7, lat1: 7};
    vecs[4] = '{a: 8'd9,  b: 8'd2,  z: 8'd18,  lat0: 7, lat1: 6};
    vecs[5] = '{a: 8'd1,  b: 8'd8,  z: 8'd8,   lat0: 7, lat1: 7};
    vecs[6] = '{a: 8'd2,  b: 8'd3,  z: 8'd6,   lat0: 7, lat1: 6};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    a_in  = '0;
    b_in  = '0;

    // Reset values
    #12;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset[%0d] outputs", i),
            int'({x_op[i], y_op[i], z_op[i], ula_op[i], val_sel[i], busy[i], done[i]}), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven products and latencies
    for (int v = 0; v < 7; v++) begin
      run(vecs[v].a, vecs[v].b, 32'h1, 32'h0, 12);
      check_result($sformatf("vec%0d", v), 0, vecs[v].lat0, int'(vecs[v].z));
      check_result($sformatf("vec%0d", v), 1, vecs[v].lat1, int'(vecs[v].z));
    end

    // z_op sequence and busy window for 3*5
    run(8'd3, 8'd5, 32'h1, 32'h0, 12);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("seq[%0d] zop_exec1", i), int'(zop_log[i][3]), int'(LOAD));
      check($sformatf("seq[%0d] zop_exec2", i), int'(zop_log[i][4]), int'(HOLD));
      check($sformatf("seq[%0d] zop_exec3", i), int'(zop_log[i][5]), int'(LOAD));
      check($sformatf("seq[%0d] zop_exec4", i), int'(zop_log[i][6]), int'(HOLD));
      check($sformatf("seq[%0d] zop_loadx", i), int'(zop_log[i][1]), int'(CLEAR));
      check($sformatf("seq[%0d] busy_idle", i), int'(busy_log[i][8]), 0);
      for (int k = 1; k <= 6; k++) begin
        check($sformatf("seq[%0d] busy_c%0d", i, k), int'(busy_log[i][k]), 1);
      end
    end

    // start pulsed during EXEC and during DONE is dropped
    run(8'd3, 8'd5, 32'h91, 32'h0, 16);
    for (int i = 0; i < 2; i++) begin
      check_result("restart_ignored", i, 7, 15);
      check($sformatf("restart_ignored[%0d] busy_exec", i), int'(busy_log[i][4]), 1);
    end

    // start in the first IDLE cycle after DONE is accepted
    run(8'd3, 8'd5, 32'h101, 32'h0, 18);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("back_to_back[%0d] done_pulses", i), done_count(i), 2);
      check($sformatf("back_to_back[%0d] second_done", i), int'(done_log[i][15]), 1);
      check($sformatf("back_to_back[%0d] second_product", i), int'(z_log[i][15]), 15);
    end

    // abort together with start in IDLE: start wins
    run(8'd3, 8'd5, 32'h1, 32'h1, 12);
    for (int i = 0; i < 2; i++) begin
      check_result("abort_in_idle", i, 7, 15);
    end

    // abort in the 2nd EXEC cycle, then 2*3
    run(8'd3, 8'd5, 32'h1, 32'h10, 12);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("abort_exec[%0d] done_pulses", i), done_count(i), 0);
      check($sformatf("abort_exec[%0d] busy_before", i), int'(busy_log[i][4]), 1);
      check($sformatf("abort_exec[%0d] busy_after", i), int'(busy_log[i][5]), 0);
    end
    run(8'd2, 8'd3, 32'h1, 32'h0, 12);
    check_result("after_abort", 0, 7, 6);
    check_result("after_abort", 1, 6, 6);

    // abort on the EXEC->DONE cycle suppresses done
    run(8'd3, 8'd5, 32'h1, 32'h40, 12);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("abort_last[%0d] done_pulses", i), done_count(i), 0);
      check($sformatf("abort_last[%0d] busy_after", i), int'(busy_log[i][7]), 0);
    end

    // Asynchronous reset in the middle of EXEC
    a_in  = 8'd3;
    b_in  = 8'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("pre_reset[%0d] busy", i), int'(busy[i]), 1);
    end
    #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("async_reset[%0d] outputs", i),
            int'({x_op[i], y_op[i], z_op[i], ula_op[i], val_sel[i], busy[i], done[i]}), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(8'd3, 8'd1, 32'h0, 32'h0, 6);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("post_reset_idle[%0d] done_pulses", i), done_count(i), 0);
      check($sformatf("post_reset_idle[%0d] busy", i), int'(busy_log[i][3]), 0);
    end
    run(8'd3, 8'd1, 32'h1, 32'h0, 12);
    check_result("post_reset", 0, 7, 3);
    check_result("post_reset", 1, 5, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
